// File: rtl/uart_rx_core.sv
// uart_rx_core: UART serial receive engine feeding the RX FIFO.
// Synchronises rxd, oversamples 16x per bit off an integer baud divider, and
// decodes start / 8 data (LSB first) / optional parity / stop with 3-sample
// majority voting. Completed bytes plus error flags leave over valid/ready.
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   enable                  receiver enable; low forces IDLE
//   div_int                 PCLK cycles per oversample tick (0 acts as 1)
//   parity_en, parity_odd   parity bit present / odd parity select
//   rxd                     asynchronous serial input, idle high
//   rx_data, rx_frame_err,
//   rx_parity_err, rx_valid,
//   rx_ready                word handshake towards the FIFO
//   rx_done, overrun,
//   break_det               single-cycle event pulses
//   rx_busy                 receiver state is not IDLE
module uart_rx_core #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_int,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rxd,
  output logic [7:0]           rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_done,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 rx_busy
);

  localparam int unsigned SCNT_W = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic [DIV_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SCNT_W-1:0]      samp_cnt_q, samp_cnt_d;
  logic [1:0]             vote_q, vote_d;
  logic                   bit_q, bit_d;
  logic [BYTE_W-1:0]      shift_q, shift_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   par_err_q, par_err_d;
  logic [BYTE_W-1:0]      data_q, data_d;
  logic                   fe_q, fe_d, pe_q, pe_d, valid_q, valid_d;
  logic                   done_q, ovr_q, brk_q, busy_q;

  logic                   rxd_s, start_c, tick_c, maj_c, bit_end_c, stop_dec_c;
  logic                   break_c, word_c, load_c, ovr_c;
  logic [DIV_WIDTH-1:0]   div_eff;
  logic [SCNT_W-1:0]      cnt_nxt;

  assign rxd_s   = sync_q[SYNC_STAGES-1];
  assign start_c = (state_q == S_IDLE) & enable & last_q & ~rxd_s;
  assign div_eff = (div_int == '0) ? DIV_WIDTH'(1) : div_int;
  // >= keeps the counter bounded if div_int shrinks mid-count
  assign tick_c  = (tick_cnt_q >= (div_eff - DIV_WIDTH'(1)));
  assign cnt_nxt = samp_cnt_q + SCNT_W'(1);
  // third vote is the live sample so the stop bit can resolve on its count-9 tick
  assign maj_c   = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);
  assign bit_end_c  = tick_c & (cnt_nxt == SCNT_W'(15));
  assign stop_dec_c = enable & tick_c & (state_q == S_STOP) & (cnt_nxt == SCNT_W'(9));

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_c) state_d = S_START;
        S_START:  if (bit_end_c) state_d = bit_q ? S_IDLE : S_DATA;
        S_DATA:   if (bit_end_c && (bit_idx_q == 3'd7)) state_d = parity_en ? S_PARITY : S_STOP;
        S_PARITY: if (bit_end_c) state_d = S_STOP;
        S_STOP:   if (stop_dec_c) state_d = break_c ? S_BREAK : S_IDLE;
        S_BREAK:  if (rxd_s) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Frame outcome decode at the stop decision
  always_comb begin
    break_c = stop_dec_c & ~maj_c & (shift_q == '0) & ~par_err_q;
    word_c  = stop_dec_c & ~break_c;
    load_c  = word_c & (~valid_q | rx_ready);
    ovr_c   = word_c & valid_q & ~rx_ready;
  end

  // Datapath next-state
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    samp_cnt_d = samp_cnt_q;
    vote_d     = vote_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    par_err_d  = par_err_q;
    if (state_q == S_IDLE) begin
      tick_cnt_d = '0;
      samp_cnt_d = '0;
    end else if (tick_c) begin
      tick_cnt_d = '0;
      samp_cnt_d = cnt_nxt;
      case (cnt_nxt)
        SCNT_W'(7): vote_d[1] = rxd_s;
        SCNT_W'(8): vote_d[0] = rxd_s;
        SCNT_W'(9): bit_d     = maj_c;
        default:    ;
      endcase
    end else begin
      tick_cnt_d = tick_cnt_q + DIV_WIDTH'(1);
    end
    if (start_c) begin
      bit_idx_d = '0;
      par_err_d = 1'b0;
    end
    if ((state_q == S_DATA) && bit_end_c) begin
      shift_d   = {bit_q, shift_q[BYTE_W-1:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end
    if ((state_q == S_PARITY) && bit_end_c) begin
      par_err_d = bit_q ^ (^shift_q) ^ parity_odd;
    end
    valid_d = load_c | (valid_q & ~rx_ready);
    data_d  = load_c ? shift_q : data_q;
    fe_d    = load_c ? ~maj_c : fe_q;
    pe_d    = load_c ? par_err_q : pe_q;
  end

  // Datapath and output registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync_q     <= '1;
      last_q     <= 1'b1;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      vote_q     <= '0;
      bit_q      <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      par_err_q  <= 1'b0;
      data_q     <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
      last_q     <= rxd_s;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      vote_q     <= vote_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      par_err_q  <= par_err_d;
      data_q     <= data_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      valid_q    <= valid_d;
      done_q     <= load_c;
      ovr_q      <= ovr_c;
      brk_q      <= break_c;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign rx_data       = data_q;
  assign rx_frame_err  = fe_q;
  assign rx_parity_err = pe_q;
  assign rx_valid      = valid_q;
  assign rx_done       = done_q;
  assign overrun       = ovr_q;
  assign break_det     = brk_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench for uart_rx_core. Frames are driven on
// the pin at bit-time granularity; expected words, flags and break events come
// from a frame-level reference model (bit counting, not a state machine).
module tb_uart_rx_core;

  logic        PCLK = 1'b0;
  logic        PRESET, enable, parity_en, parity_odd, rxd, rx_ready;
  logic [15:0] div_int;
  logic [7:0]  rx_data;
  logic        rx_frame_err, rx_parity_err, rx_valid, rx_done, overrun, break_det, rx_busy;

  uart_rx_core #(.DIV_WIDTH(16), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .enable(enable), .div_int(div_int),
    .parity_en(parity_en), .parity_odd(parity_odd), .rxd(rxd),
    .rx_data(rx_data), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_done(rx_done),
    .overrun(overrun), .break_det(break_det), .rx_busy(rx_busy)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int ovr_cnt  = 0;
  int brk_cnt  = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;
  logic [9:0] acc_q[$];   // accepted words: {parity_err, frame_err, data}

  // Event monitor, sampled shortly after the falling edge
  always @(negedge PCLK) begin
    #1;
    if (PRESET) begin
      valid_prev = 1'b0;
    end else begin
      if (rx_done)   done_cnt++;
      if (overrun)   ovr_cnt++;
      if (break_det) brk_cnt++;
      if (rx_valid && rx_ready) acc_q.push_back({rx_parity_err, rx_frame_err, rx_data});
      if (rx_valid && !valid_prev && rise_cyc < 0) rise_cyc = cyc;
      valid_prev = rx_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bt_of(input int div);
    return 16 * ((div == 0) ? 1 : div);
  endfunction

  task automatic hold(input logic b, input int n);
    rxd = b;
    repeat (n) @(negedge PCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int bt);
    hold(1'b0, bt);
    for (int i = 0; i < 8; i++) hold(d[i], bt);
    if (pen) hold(pbit, bt);
    hold(stop, bt);
    rxd = 1'b1;
  endtask

  // Drive one frame and compare against the frame-level model
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic podd, input logic pbit, input logic stop, input int div);
    int n0, b0, bt, ones;
    logic par_ok, is_brk;
    logic [9:0] w;
    parity_en  = pen;
    parity_odd = podd;
    div_int    = 16'(div);
    bt = bt_of(div);
    n0 = acc_q.size();
    b0 = brk_cnt;
    send_frame(d, pen, pbit, stop, bt);
    hold(1'b1, bt);
    ones   = $countones(d) + int'(pbit);
    par_ok = !pen || ((ones % 2) == (podd ? 1 : 0));
    is_brk = !stop && (d == 8'h00) && par_ok;
    check({tag, "_break"}, 32'(brk_cnt - b0), is_brk ? 32'd1 : 32'd0);
    check({tag, "_words"}, 32'(acc_q.size() - n0), is_brk ? 32'd0 : 32'd1);
    if (acc_q.size() > n0) begin
      w = acc_q[$];
      check({tag, "_data"}, 32'(w[7:0]), 32'(d));
      check({tag, "_ferr"}, 32'(w[8]), 32'(!stop));
      check({tag, "_perr"}, 32'(w[9]), 32'(pen && !par_ok));
    end
  endtask

  initial begin
    int t0, n0, d0, o0, b0, lat;
    logic [7:0] d;
    PRESET = 1'b1; rxd = 1'b1; enable = 1'b1; parity_en = 1'b0;
    parity_odd = 1'b0; rx_ready = 1'b1; div_int = 16'd16;
    repeat (3) @(negedge PCLK);
    check("rst_outputs", 32'({rx_data, rx_frame_err, rx_parity_err, rx_valid,
                              rx_done, overrun, break_det}), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    PRESET = 1'b0;
    repeat (4) @(negedge PCLK);

    // 8N1 0x55 at div 16 with latency window
    rise_cyc = -1;
    t0 = cyc;
    d0 = done_cnt;
    run_frame("f55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    lat = rise_cyc - t0;
    check("f55_latency", 32'((lat >= 2419) && (lat <= 2451)), 32'd1);
    check("f55_done", 32'(done_cnt - d0), 32'd1);

    // Glitch shorter than half a bit is a false start
    n0 = acc_q.size();
    hold(1'b0, 100);
    check("glitch_busy", 32'(rx_busy), 32'd1);
    hold(1'b1, 156);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    hold(1'b1, 256);
    check("glitch_words", 32'(acc_q.size() - n0), 32'd0);
    run_frame("fA5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16);

    // Even parity: wrong then right parity bit
    run_frame("parbad", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 16);
    run_frame("parok",  8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 16);

    // Framing error, then a long break
    run_frame("ferr", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    n0 = acc_q.size();
    b0 = brk_cnt;
    hold(1'b0, 19 * 256);
    check("brk_busy", 32'(rx_busy), 32'd1);
    hold(1'b0, 256);
    check("brk_count", 32'(brk_cnt - b0), 32'd1);
    check("brk_words", 32'(acc_q.size() - n0), 32'd0);
    rxd = 1'b1;
    repeat (8) @(negedge PCLK);
    check("brk_release", 32'(rx_busy), 32'd0);
    hold(1'b1, 512);

    // Overrun with back-to-back frames under backpressure
    rx_ready = 1'b0;
    n0 = acc_q.size(); d0 = done_cnt; o0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 256);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 256);
    hold(1'b1, 512);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_held_data", 32'(rx_data), 32'h11);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_done", 32'(done_cnt - d0), 32'd1);
    rx_ready = 1'b1;
    @(negedge PCLK);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);
    repeat (2) @(negedge PCLK);
    check("ovr_xfers", 32'(acc_q.size() - n0), 32'd1);
    if (acc_q.size() > n0) check("ovr_xfer_data", 32'(acc_q[$][7:0]), 32'h11);

    // Reset mid-frame drops the held word and the frame in flight
    rx_ready = 1'b0;
    n0 = acc_q.size();
    send_frame(8'h42, 1'b0, 1'b0, 1'b1, 256);
    hold(1'b1, 512);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    d = 8'h3C;
    hold(1'b0, 256);
    for (int i = 0; i < 4; i++) hold(d[i], 256);
    hold(d[4], 128);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("midrst_outputs", 32'({rx_data, rx_frame_err, rx_parity_err, rx_valid,
                                 rx_done, overrun, break_det, rx_busy}), 32'd0);
    PRESET = 1'b0;
    rxd = 1'b1;
    rx_ready = 1'b1;
    hold(1'b1, 1024);
    check("midrst_words", 32'(acc_q.size() - n0), 32'd0);

    // div_int = 0 behaves as 1
    run_frame("div0", 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Disable mid-frame
    div_int = 16'd16;
    parity_en = 1'b0;
    n0 = acc_q.size(); b0 = brk_cnt;
    hold(1'b0, 400);
    enable = 1'b0;
    repeat (2) @(negedge PCLK);
    check("dis_busy", 32'(rx_busy), 32'd0);
    hold(1'b1, 600);
    enable = 1'b1;
    hold(1'b1, 256);
    check("dis_words", 32'(acc_q.size() - n0 + brk_cnt - b0), 32'd0);

    // Randomised frames against the model
    for (int i = 0; i < 24; i++) begin
      logic [7:0] rd;
      rd = 8'($urandom);
      if (($urandom % 6) == 0) rd = 8'h00;
      run_frame($sformatf("rnd%0d", i), rd, 1'($urandom), 1'($urandom), 1'($urandom),
                (($urandom % 4) != 0), int'($urandom % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive engine that sits directly upstream of the RX FIFO inside the APB UART. It synchronises RXD and oversamples it 16x using an integer baud divider. Each frame (start, 8 data LSB-first, optional parity, 1 stop) is decoded with majority voting. The byte and its error flags are handed to the FIFO over a valid/ready interface.

Parameters:
DIV_WIDTH, 16, width of baud divider input
SYNC_STAGES, 2, flops in RXD synchroniser (>=2)

Ports:
PCLK  in  1  system clock
PRESET  in  1  reset, synchronous, active-high
enable  in  1  receiver enable (CTRL.enable & CTRL.RX_EN)
div_int  in  DIV_WIDTH  PCLK cycles per oversample tick; 0 treated as 1
parity_en  in  1  parity bit present after data
parity_odd  in  1  1=odd, 0=even parity
rxd  in  1  serial input, idle high (asynchronous)
rx_data  out  8  received byte
rx_frame_err  out  1  stop bit sampled 0, qualified by rx_valid
rx_parity_err  out  1  parity mismatch, qualified by rx_valid
rx_valid  out  1  word available
rx_ready  in  1  FIFO accepts word
rx_done  out  1  1-cycle pulse per completed, delivered frame
overrun  out  1  1-cycle pulse, frame dropped because rx_valid still held
break_det  out  1  1-cycle pulse on break condition
rx_busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops and last-sample register = 1, counters 0.
- Synchroniser: SYNC_STAGES flops; synced rxd lags pin by SYNC_STAGES cycles.
- Tick generator: counter 0..max(div_int,1)-1, tick on terminal count; cleared on start detect. One bit = 16 ticks = 16*div_int PCLK.
- Sample counter 0..15 advances per tick. Samples at counts 7,8,9 are captured; majority of the 3 is the bit value.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: falling edge on synced rxd (previous 1, current 0) with enable=1 -> START; tick and sample counters cleared.
- START: at count 15, majority 1 -> false start, IDLE, nothing emitted; else DATA.
- DATA: 8 bits LSB-first, each decided at count 15. After bit 7 -> PARITY if parity_en, else STOP.
- PARITY: expected bit = XOR(data) ^ parity_odd; mismatch latched at count 15.
- STOP: decided at tick of count 9 (half-bit early, allows back-to-back frames). Outcomes:
  - stop=0, data=0x00, parity ok or disabled -> break_det pulse, no word, BREAK.
  - else word is emitted, IDLE.
- BREAK: wait for synced rxd=1, then IDLE.
- Emit (cycle after STOP decision):
  - rx_valid=0 or rx_ready=1 that cycle -> load rx_data/flags, rx_valid=1, rx_done pulse.
  - otherwise -> overrun pulse; held word and flags unchanged.
- Handshake: transfer when rx_valid & rx_ready. rx_valid deasserts the next cycle unless a new word loads in the same cycle. rx_data and flags are stable while rx_valid=1 and not accepted.
- enable=0: any state -> IDLE next cycle, partial frame discarded, no pulses. rx_valid/rx_data retained until accepted.
- div_int change mid-frame: takes effect at next tick-counter reload. No glitch requirement on the frame in flight.
- PRESET mid-frame: immediate return to reset values next edge, pending word lost.

Test Plan:
- div_int=16, 8N1, send 0x55, rx_ready=1 -> rx_valid with rx_data=0x55, both error flags 0. rx_valid rises 9.5*256 (+/-16) + SYNC_STAGES+1 cycles after pin falling edge. rx_done one pulse.
- Glitch: rxd low 100 PCLK then high (div_int=16) -> no rx_valid, rx_busy drops by cycle 256 after edge, state IDLE. Follow with valid 0xA5 -> received correctly.
- parity_en=1, parity_odd=0, send 0xA5 with parity bit 1 -> rx_data=0xA5, rx_parity_err=1. Correct parity bit 0 -> rx_parity_err=0.
- Send 0x5A with stop=0 -> rx_frame_err=1, rx_data=0x5A. Hold rxd low 20 bit times -> exactly one break_det, no rx_valid, rx_busy=1 until rxd returns high.
- Overrun: rx_ready=0, send 0x11 then 0xFF back-to-back -> rx_data stays 0x11, overrun single pulse at 2nd stop. Raise rx_ready -> one transfer of 0x11, rx_valid drops.
- Mid-frame PRESET after bit 3 of 0x3C -> all outputs 0 next cycle, no word. div_int=0 with 0x96 at 16 PCLK/bit -> 0x96 received.
